prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Host-side sequencer that drives the core's `Start` input and consumes its `Done` output, running up to `NPROG` programs back-to-back. It sits in the top-level test wrapper between the host/testbench `Go` pulse and the processor. It also measures per-program cycle counts and enforces a watchdog timeout.

## Interface
Parameters:
- `NPROG`, default 3: number of programs to run per `Go` (1..4).
- `HOLD`, default 2: number of cycles `Start` is held high per program (≥1).
- `CW`, default 16: cycle-counter width.
- `MAXCYC`, default 16'hFFFF: watchdog limit, in RUN cycles (< 2^CW).

Ports:
- `Clk` in 1: single clock; all state changes on the posedge.
- `Reset` in 1: asynchronous, active-high; forces all state to reset values.
- `Go` in 1: one-cycle request to start a full sequence. Honored only in IDLE.
- `Done` in 1: core completion flag. Sampled only in RUN.
- `Start` out 1: to the core; high during ASSERT only.
- `ProgIdx` out 2: index of the current or last program, 0-based.
- `Busy` out 1: high in every state except IDLE.
- `LastCycles` out CW: RUN-cycle count latched for the most recent program.
- `AllDone` out 1: one-cycle pulse when the final program ends.
- `TimedOut` out 1: sticky flag; set if any program hits `MAXCYC`. Cleared by `Reset` or an accepted `Go`.

## Operation
- States: IDLE, ASSERT, RUN, NEXT.
- IDLE, with `Go`=1:
  - `ProgIdx`←0, `TimedOut`←0, hold counter←0.
  - Next state is ASSERT.
- ASSERT:
  - `Start`=1.
  - Hold counter increments each cycle.
  - When it reaches `HOLD`-1, move to RUN with the run counter←0.
  - `Done` is ignored in this state.
- RUN, `Start`=0:
  - `Done`=1: `LastCycles`←run counter, then go to NEXT.
  - Otherwise, if run counter == `MAXCYC`: `LastCycles`←`MAXCYC`, `TimedOut`←1, then go to NEXT.
  - Otherwise the run counter increments.
  - `Done` takes priority over timeout when both occur in the same cycle.
- NEXT, which lasts one cycle:
  - If `ProgIdx`==`NPROG`-1: pulse `AllDone`, go to IDLE, and `ProgIdx` holds.
  - Otherwise `ProgIdx`+1, hold counter←0, go to ASSERT.
- `Go` outside IDLE is ignored and is not queued.
- Counters do not wrap, because the run counter is compared against `MAXCYC` before it increments.

## Timing
- Reset values: state IDLE, `Start`=0, `ProgIdx`=0, `Busy`=0, `LastCycles`=0, `AllDone`=0, `TimedOut`=0.
- `Reset` asserted mid-sequence gives immediate (asynchronous) return to these values. `Start` drops without waiting for a clock edge.
- Cycle numbering: `Go` is sampled high at edge k. `Start` is high for cycles k+1 .. k+`HOLD`. The first RUN cycle is k+`HOLD`+1.
- Cycle-count latency:
  - `Done` high in the first RUN cycle gives `LastCycles`=0.
  - `Done` high n cycles after the first RUN cycle gives `LastCycles`=n.
  - `LastCycles` updates at the edge ending the `Done` cycle.
- Per-program overhead: `HOLD` + 1 (NEXT) cycles between the `Done` cycle and the next RUN.
- `Busy` is registered from state. It goes high the cycle after `Go` and low the cycle after `AllDone`.
- `Start` and `AllDone` are Moore outputs and are never both high.

## Structure
- The shared package `prog_seq_pkg` holds:
  - the `typedef enum logic [1:0] {IDLE, ASSERT, RUN, NEXT}` state type;
  - the default-parameter constants, which are reused by the top-level wrapper and the bench.
- There is no sub-module. One `always_ff` block holds state and counters, and one `always_comb` block computes next-state and outputs.

## Test plan
- Basic sequence: `NPROG`=3, `HOLD`=2, `Go` at cycle 5, `Done` asserted 10 cycles into each RUN.
  - `Start` must be high in cycles 6–7.
  - `LastCycles` must be 10 after each program.
  - `ProgIdx` must step 0→1→2.
  - `AllDone` must pulse once.
  - `TimedOut` must stay 0.
- Immediate Done: `Done` held high constantly.
  - `LastCycles`=0 for every program.
  - `Done` during ASSERT must not shorten `Start`, which stays exactly 2 cycles.
- Watchdog: `MAXCYC`=20 and `Done` never rises.
  - Each program ends with `LastCycles`=20 and `TimedOut`=1 sticky.
  - The sequence must still reach `AllDone`.
- Done at limit: `Done` rises on the same cycle the run counter equals `MAXCYC`.
  - `LastCycles`=`MAXCYC` and `TimedOut` stays 0.
- `Go` while busy: a second `Go` in RUN of program 1 is ignored.
  - `ProgIdx` continues 1→2 and `AllDone` pulses once.
- Reset mid-run: `Reset` pulse during ASSERT of program 1.
  - `Start` drops asynchronously and all outputs return to reset values.
  - A subsequent `Go` restarts at `ProgIdx`=0.

Source files
------------

// File: rtl/prog_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_seq_pkg
// Description : Shared state type and default parameters for prog_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    RUN    = 2'd2,
    NEXT   = 2'd3
  } state_t;

  localparam int unsigned c_def_nprog  = 3;
  localparam int unsigned c_def_hold   = 2;
  localparam int unsigned c_def_cw     = 16;
  localparam int unsigned c_def_maxcyc = 32'h0000_FFFF;

endpackage : prog_seq_pkg
`default_nettype wire

// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : prog_sequencer
// Description : Runs NPROG programs back-to-back on the core, measuring each
//               program's RUN cycles and enforcing a watchdog limit.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned NPROG  = c_def_nprog,
  parameter int unsigned HOLD   = c_def_hold,
  parameter int unsigned CW     = c_def_cw,
  parameter int unsigned MAXCYC = c_def_maxcyc
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic          Done,
  output logic          Start,
  output logic [1:0]    ProgIdx,
  output logic          Busy,
  output logic [CW-1:0] LastCycles,
  output logic          AllDone,
  output logic          TimedOut
);

  localparam int unsigned   HW          = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] c_hold_last = HW'(HOLD - 1);
  localparam logic [HW-1:0] c_hold_one  = HW'(1);
  localparam logic [CW-1:0] c_maxcyc    = CW'(MAXCYC);
  localparam logic [CW-1:0] c_run_one   = CW'(1);
  localparam logic [1:0]    c_last_idx  = 2'(NPROG - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_hold_cnt;
  logic [CW-1:0] r_run_cnt;
  logic [1:0]    r_prog_idx;
  logic [CW-1:0] r_last_cycles;
  logic          r_timed_out;

  // Start/AllDone/Busy decode only the state register, so they are glitch-free
  // Moore outputs and Start falls as soon as Reset clears the state.
  always_comb begin
    w_state_nxt = r_state;
    Start       = 1'b0;
    Busy        = 1'b1;
    AllDone     = 1'b0;
    case (r_state)
      IDLE: begin
        Busy = 1'b0;
        if (Go) w_state_nxt = ASSERT;
      end
      ASSERT: begin
        Start = 1'b1;
        if (r_hold_cnt == c_hold_last) w_state_nxt = RUN;
      end
      RUN: begin
        if (Done || (r_run_cnt == c_maxcyc)) w_state_nxt = NEXT;
      end
      NEXT: begin
        if (r_prog_idx == c_last_idx) begin
          AllDone     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ASSERT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_hold_cnt    <= '0;
      r_run_cnt     <= '0;
      r_prog_idx    <= '0;
      r_last_cycles <= '0;
      r_timed_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (Go) begin
            r_prog_idx  <= '0;
            r_timed_out <= 1'b0;
            r_hold_cnt  <= '0;
          end
        end
        ASSERT: begin
          if (r_hold_cnt == c_hold_last) r_run_cnt <= '0;
          else                           r_hold_cnt <= r_hold_cnt + c_hold_one;
        end
        RUN: begin
          // Done wins over the watchdog when both land in the same cycle
          if (Done) begin
            r_last_cycles <= r_run_cnt;
          end else if (r_run_cnt == c_maxcyc) begin
            r_last_cycles <= c_maxcyc;
            r_timed_out   <= 1'b1;
          end else begin
            r_run_cnt <= r_run_cnt + c_run_one;
          end
        end
        NEXT: begin
          if (r_prog_idx != c_last_idx) begin
            r_prog_idx <= r_prog_idx + 2'd1;
            r_hold_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ProgIdx    = r_prog_idx;
  assign LastCycles = r_last_cycles;
  assign TimedOut   = r_timed_out;

endmodule : prog_sequencer
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_sequencer
// Description : Self-checking bench; expected outputs come from a per-program
//               timeline model built from the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_sequencer;
  import prog_seq_pkg::*;

  localparam int NP  = c_def_nprog;
  localparam int HD  = c_def_hold;
  localparam int CWL = c_def_cw;
  localparam int MC  = 20;
  localparam int L   = 160;

  localparam int M_BASIC = 0;
  localparam int M_IMM   = 1;
  localparam int M_WDOG  = 2;
  localparam int M_LIMIT = 3;
  localparam int M_RAND  = 4;

  logic           Clk;
  logic           Reset;
  logic           Go;
  logic           Done;
  logic           Start;
  logic [1:0]     ProgIdx;
  logic           Busy;
  logic [CWL-1:0] LastCycles;
  logic           AllDone;
  logic           TimedOut;

  int total = 0;
  int bad   = 0;

  // Timeline arrays indexed by cycle after the edge that accepts Go
  bit done_pat[L];
  bit go_pat[L];
  bit in_run[L];
  bit e_start[L];
  bit e_busy[L];
  bit e_ad[L];
  bit e_to[L];
  int e_idx[L];
  int e_last[L];
  int prog_start[4];
  int seq_end;

  int m_last = 0;
  int m_idx  = 0;
  bit m_to   = 0;
  int n_last;
  bit n_to;

  prog_sequencer #(
    .NPROG (NP),
    .HOLD  (HD),
    .CW    (CWL),
    .MAXCYC(MC)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Go        (Go),
    .Done      (Done),
    .Start     (Start),
    .ProgIdx   (ProgIdx),
    .Busy      (Busy),
    .LastCycles(LastCycles),
    .AllDone   (AllDone),
    .TimedOut  (TimedOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_all(input int t, input bit st, input bit bz, input bit ad,
                         input int idx, input int last, input bit to);
    chk("start",    t, {31'd0, Start},      {31'd0, st});
    chk("busy",     t, {31'd0, Busy},       {31'd0, bz});
    chk("alldone",  t, {31'd0, AllDone},    {31'd0, ad});
    chk("progidx",  t, {30'd0, ProgIdx},    32'(idx));
    chk("lastcyc",  t, {16'd0, LastCycles}, 32'(last));
    chk("timedout", t, {31'd0, TimedOut},   {31'd0, to});
  endtask

  task automatic set_exp(input int t, input bit st, input bit bz, input bit ad,
                         input int idx, input int last, input bit to);
    e_start[t] = st; e_busy[t] = bz; e_ad[t] = ad;
    e_idx[t]   = idx; e_last[t] = last; e_to[t] = to;
  endtask

  task automatic build(input int mode, input bit go_noise);
    int s, d, n, cur_last;
    bit cur_to;
    for (int i = 0; i < L; i++) begin
      done_pat[i] = 1'b0; go_pat[i] = 1'b0; in_run[i] = 1'b0;
    end
    s = HD; cur_last = m_last; cur_to = 1'b0;
    for (int p = 0; p < NP; p++) begin
      prog_start[p] = s;
      for (int t = s - HD; t < s; t++) set_exp(t, 1, 1, 0, p, cur_last, cur_to);
      case (mode)
        M_BASIC: d = 10;
        M_IMM:   d = 0;
        M_WDOG:  d = 999;
        M_LIMIT: d = MC;
        default: d = int'($urandom_range(0, MC + 4));
      endcase
      n = (d <= MC) ? d : MC;
      if (d <= MC) done_pat[s + d] = 1'b1;
      for (int t = s; t <= s + n; t++) begin
        set_exp(t, 0, 1, 0, p, cur_last, cur_to);
        in_run[t] = 1'b1;
      end
      cur_last = n;
      if (d > MC) cur_to = 1'b1;
      set_exp(s + n + 1, 0, 1, (p == NP - 1), p, cur_last, cur_to);
      seq_end = s + n + 1;
      s = s + n + 2 + HD;
    end
    for (int t = seq_end + 1; t < L; t++) set_exp(t, 0, 0, 0, NP - 1, cur_last, cur_to);
    for (int t = 0; t <= seq_end; t++) begin
      if (mode == M_IMM) done_pat[t] = 1'b1;
      else if (mode == M_RAND && !in_run[t]) done_pat[t] = 1'($urandom_range(0, 1));
      if (go_noise) go_pat[t] = ($urandom_range(0, 5) == 0);
    end
    if (go_noise) go_pat[prog_start[1] + 3] = 1'b1;
    n_last = cur_last; n_to = cur_to;
  endtask

  // stop_at >= 0 abandons the sequence after checking that cycle
  task automatic run_seq(input int stop_at);
    @(posedge Clk); #2;
    chk_all(-1, 0, 0, 0, m_idx, m_last, m_to);
    Go = 1'b1; Done = 1'b0;
    for (int t = 0; t <= seq_end + 2; t++) begin
      @(posedge Clk); #2;
      chk_all(t, e_start[t], e_busy[t], e_ad[t], e_idx[t], e_last[t], e_to[t]);
      if (t == stop_at) return;
      Go = go_pat[t]; Done = done_pat[t];
    end
    Go = 1'b0; Done = 1'b0;
    m_last = n_last; m_idx = NP - 1; m_to = n_to;
  endtask

  initial begin
    Reset = 1'b1; Go = 1'b0; Done = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    chk_all(-2, 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;

    build(M_BASIC, 0); run_seq(-1);
    build(M_IMM,   0); run_seq(-1);
    build(M_WDOG,  0); run_seq(-1);
    build(M_LIMIT, 0); run_seq(-1);
    build(M_BASIC, 1); run_seq(-1);

    // Reset pulse in the first ASSERT cycle of program 1
    build(M_BASIC, 0); run_seq(prog_start[1] - HD);
    #1 Reset = 1'b1;
    #1 chk_all(-3, 0, 0, 0, 0, 0, 0);
    Go = 1'b0; Done = 1'b0;
    @(posedge Clk); #3;
    Reset = 1'b0;
    m_last = 0; m_idx = 0; m_to = 1'b0;

    for (int k = 0; k < 4; k++) begin
      build(M_RAND, 1'(k[0])); run_seq(-1);
    end
    build(M_WDOG, 1); run_seq(-1);
    build(M_RAND, 0); run_seq(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_prog_sequencer
`default_nettype wire
